// File: rtl/llm_int8_pkg.sv
// Shared types and helpers for the int8 absmax quantizer.
package llm_int8_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // Largest symmetric magnitude representable in a qw-bit signed output.
    function automatic int unsigned qmax(input int unsigned qw);
        return (32'd1 << (qw - 32'd1)) - 32'd1;
    endfunction

    // Magnitude of a sign-extended element; callers narrow to their element width.
    function automatic logic [31:0] abs_u(input logic signed [31:0] x);
        return x[31] ? 32'(-x) : 32'(x);
    endfunction

endpackage

// File: rtl/llm_int8_shift_round_sat.sv
// Per-element arithmetic shift with optional round-half-up, saturated to [-QMAX, +QMAX].
// Rounding is enabled by defining LLM_INT8_ABSMAX_ROUND_EN.
module llm_int8_shift_round_sat
    import llm_int8_pkg::*;
#(
    parameter int unsigned IN_WIDTH           = 16,
    parameter int unsigned QUANTIZATION_WIDTH = 8,
    parameter int unsigned SHIFT_WIDTH        = $clog2(IN_WIDTH)
) (
    input  logic [IN_WIDTH-1:0]           x,
    input  logic [SHIFT_WIDTH-1:0]        s,
    output logic [QUANTIZATION_WIDTH-1:0] q_c
);

    localparam int unsigned WW = IN_WIDTH + 1;
    localparam logic signed [WW-1:0] QMAX_W = WW'(qmax(QUANTIZATION_WIDTH));

    logic signed [WW-1:0] x_ext;
    logic signed [WW-1:0] bias;
    logic signed [WW-1:0] shifted;

    // One spare bit keeps the rounding add from overflowing near +max.
    always_comb begin
        x_ext = {x[IN_WIDTH-1], x};
        bias  = '0;
`ifdef LLM_INT8_ABSMAX_ROUND_EN
        if (s != '0) begin
            bias = WW'(1) << (s - SHIFT_WIDTH'(1));
        end
`endif
        shifted = (x_ext + bias) >>> s;
        if (shifted > QMAX_W) begin
            q_c = QUANTIZATION_WIDTH'(QMAX_W);
        end else if (shifted < -QMAX_W) begin
            q_c = QUANTIZATION_WIDTH'(-QMAX_W);
        end else begin
            q_c = shifted[QUANTIZATION_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/llm_int8_absmax_quant.sv
// Buffers one tile, derives a per-row power-of-two scale from the row absmax and
// re-emits the tile as int8 plus per-row shift. Optional macro: LLM_INT8_ABSMAX_ROUND_EN.
module llm_int8_absmax_quant
    import llm_int8_pkg::*;
#(
    parameter int unsigned IN_WIDTH           = 16,
    parameter int unsigned IN_SIZE            = 4,
    parameter int unsigned IN_PARALLELISM     = 2,
    parameter int unsigned IN_DEPTH           = 3,
    parameter int unsigned QUANTIZATION_WIDTH = 8,
    parameter int unsigned SHIFT_WIDTH        = $clog2(IN_WIDTH)
) (
    input  logic                                                    clk,
    input  logic                                                    rst,
    input  logic [IN_PARALLELISM*IN_SIZE-1:0][IN_WIDTH-1:0]           data_in,
    input  logic                                                    data_in_valid,
    output logic                                                    data_in_ready,
    output logic [IN_PARALLELISM*IN_SIZE-1:0][QUANTIZATION_WIDTH-1:0] data_out,
    output logic [IN_PARALLELISM-1:0][SHIFT_WIDTH-1:0]                scale_shift,
    output logic                                                    data_out_valid,
    input  logic                                                    data_out_ready
);

    localparam int unsigned NUM_ELEMS = IN_PARALLELISM * IN_SIZE;
    localparam int unsigned CNT_W     = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
    localparam logic [CNT_W-1:0]    LAST_BEAT = CNT_W'(IN_DEPTH - 1);
    localparam logic [IN_WIDTH-1:0] QMAX_U    = IN_WIDTH'(qmax(QUANTIZATION_WIDTH));

    typedef logic [NUM_ELEMS-1:0][IN_WIDTH-1:0]           beat_t;
    typedef logic [NUM_ELEMS-1:0][QUANTIZATION_WIDTH-1:0] qbeat_t;
    typedef logic [IN_PARALLELISM-1:0][IN_WIDTH-1:0]      absmax_t;
    typedef logic [IN_PARALLELISM-1:0][SHIFT_WIDTH-1:0]   shift_t;

    state_t          state, state_nxt;
    logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;
    beat_t           buffer     [IN_DEPTH];
    beat_t           buffer_nxt [IN_DEPTH];
    absmax_t         absmax, absmax_nxt, absmax_upd;
    shift_t          scale_shift_nxt, shift_c, q_shift;
    qbeat_t          data_out_nxt, q_vals;
    logic            data_out_valid_nxt, data_in_ready_nxt;
    beat_t           q_src;
    logic [31:0]     mag;

    // Row absmax including the beat currently on data_in; restarts at beat 0.
    always_comb begin
        mag = '0;
        for (int r = 0; r < IN_PARALLELISM; r++) begin
            absmax_upd[r] = (beat_cnt == '0) ? '0 : absmax[r];
            for (int c = 0; c < IN_SIZE; c++) begin
                mag = abs_u(32'(signed'(data_in[r*IN_SIZE+c])));
                if (mag > 32'(absmax_upd[r])) begin
                    absmax_upd[r] = IN_WIDTH'(mag);
                end
            end
        end
    end

    // Smallest shift bringing the row absmax into [0, QMAX].
    always_comb begin
        for (int r = 0; r < IN_PARALLELISM; r++) begin
            shift_c[r] = SHIFT_WIDTH'(IN_WIDTH - 1);
            for (int k = IN_WIDTH - 1; k >= 0; k--) begin
                if ((absmax_upd[r] >> k) <= QMAX_U) begin
                    shift_c[r] = SHIFT_WIDTH'(k);
                end
            end
        end
    end

    // Quantizer input is the beat that will sit on data_out next cycle.
    always_comb begin
        q_src   = buffer[0];
        q_shift = scale_shift;
        if (state == FILL) begin
            q_shift = shift_c;
            if (IN_DEPTH == 1) begin
                q_src = data_in;
            end
        end else if (beat_cnt != LAST_BEAT) begin
            q_src = buffer[beat_cnt + CNT_W'(1)];
        end
    end

    for (genvar e = 0; e < NUM_ELEMS; e++) begin : g_quant
        llm_int8_shift_round_sat #(
            .IN_WIDTH          (IN_WIDTH),
            .QUANTIZATION_WIDTH(QUANTIZATION_WIDTH),
            .SHIFT_WIDTH       (SHIFT_WIDTH)
        ) u_quant (
            .x  (q_src[e]),
            .s  (q_shift[e/IN_SIZE]),
            .q_c(q_vals[e])
        );
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_nxt          = state;
        beat_cnt_nxt       = beat_cnt;
        buffer_nxt         = buffer;
        absmax_nxt         = absmax;
        scale_shift_nxt    = scale_shift;
        data_out_nxt       = data_out;
        data_out_valid_nxt = data_out_valid;
        unique case (state)
            FILL: begin
                if (data_in_valid && data_in_ready) begin
                    buffer_nxt[beat_cnt] = data_in;
                    absmax_nxt           = absmax_upd;
                    if (beat_cnt == LAST_BEAT) begin
                        scale_shift_nxt    = shift_c;
                        data_out_nxt       = q_vals;
                        data_out_valid_nxt = 1'b1;
                        beat_cnt_nxt       = '0;
                        state_nxt          = DRAIN;
                    end else begin
                        beat_cnt_nxt = beat_cnt + CNT_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (data_out_ready) begin
                    if (beat_cnt == LAST_BEAT) begin
                        beat_cnt_nxt       = '0;
                        data_out_valid_nxt = 1'b0;
                        state_nxt          = FILL;
                    end else begin
                        beat_cnt_nxt = beat_cnt + CNT_W'(1);
                        data_out_nxt = q_vals;
                    end
                end
            end
            default: state_nxt = FILL;
        endcase
        data_in_ready_nxt = (state_nxt == FILL);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= FILL;
            beat_cnt       <= '0;
            absmax         <= '0;
            scale_shift    <= '0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            data_in_ready  <= 1'b0;
            for (int b = 0; b < IN_DEPTH; b++) begin
                buffer[b] <= '0;
            end
        end else begin
            state          <= state_nxt;
            beat_cnt       <= beat_cnt_nxt;
            absmax         <= absmax_nxt;
            scale_shift    <= scale_shift_nxt;
            data_out       <= data_out_nxt;
            data_out_valid <= data_out_valid_nxt;
            data_in_ready  <= data_in_ready_nxt;
            for (int b = 0; b < IN_DEPTH; b++) begin
                buffer[b] <= buffer_nxt[b];
            end
        end
    end

endmodule

// File: tb/tb_llm_int8_absmax_quant.sv
// Self-checking bench for llm_int8_absmax_quant: spec-level model plus directed literal checks.
module tb_llm_int8_absmax_quant;

    localparam int IW = 16;
    localparam int IS = 4;
    localparam int IP = 2;
    localparam int ID = 3;
    localparam int QW = 8;
    localparam int SW = 4;
    localparam int NE = IP * IS;

    typedef logic [NE-1:0][IW-1:0] beat_t;
    typedef logic [NE-1:0][QW-1:0] qbeat_t;
    typedef logic [IP-1:0][SW-1:0] sh_t;

    logic   clk = 1'b0;
    logic   rst = 1'b0;
    beat_t  data_in = '0;
    logic   data_in_valid = 1'b0;
    logic   data_in_ready;
    qbeat_t data_out;
    sh_t    scale_shift;
    logic   data_out_valid;
    logic   data_out_ready = 1'b1;

    always #5 clk = ~clk;

    llm_int8_absmax_quant dut (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .data_out      (data_out),
        .scale_shift   (scale_shift),
        .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int     tile [ID][NE];
    qbeat_t exp_d [$];
    sh_t    exp_s [$];
    qbeat_t got_q [ID];
    sh_t    got_sh;
    int     out_idx   = 0;
    int     acc_cnt   = 0;
    int     stall_cnt = 0;
    logic   prev_stall = 1'b0;
    qbeat_t prev_d;
    sh_t    prev_s;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", name,
                     $signed(got), got, $signed(exp), exp);
        end
    endtask

    // Spec-level model: smallest s with (absmax >> s) <= 127, then shift/round/saturate.
    function automatic int m_shift(input int am);
        for (int s = 0; s < IW; s++) begin
            if ((am >> s) <= 127) return s;
        end
        return IW - 1;
    endfunction

    function automatic int m_quant(input int x, input int s);
        int y;
`ifdef LLM_INT8_ABSMAX_ROUND_EN
        y = (x + ((s > 0) ? (1 << (s - 1)) : 0)) >>> s;
`else
        y = x >>> s;
`endif
        if (y > 127)  y = 127;
        if (y < -127) y = -127;
        return y;
    endfunction

    function automatic int gq(input int b, input int e);
        return int'($signed(got_q[b][e]));
    endfunction

    task automatic model_push();
        int     sh [IP];
        qbeat_t ed;
        sh_t    es;
        for (int r = 0; r < IP; r++) begin
            int am = 0;
            for (int b = 0; b < ID; b++)
                for (int c = 0; c < IS; c++) begin
                    int v = tile[b][r*IS+c];
                    if (v < 0) v = -v;
                    if (v > am) am = v;
                end
            sh[r] = m_shift(am);
            es[r] = SW'(sh[r]);
        end
        for (int b = 0; b < ID; b++) begin
            for (int e = 0; e < NE; e++) ed[e] = QW'(m_quant(tile[b][e], sh[e/IS]));
            exp_d.push_back(ed);
            exp_s.push_back(es);
        end
    endtask

    task automatic set_row(input int b, input int r, input int a0, input int a1,
                           input int a2, input int a3);
        tile[b][r*IS+0] = a0;
        tile[b][r*IS+1] = a1;
        tile[b][r*IS+2] = a2;
        tile[b][r*IS+3] = a3;
    endtask

    function automatic beat_t pack_beat(input int b);
        beat_t x;
        for (int e = 0; e < NE; e++) x[e] = IW'(tile[b][e]);
        return x;
    endfunction

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic send_beat(input beat_t b);
        int n = 0;
        data_in       = b;
        data_in_valid = 1'b1;
        @(negedge clk);
        while (!data_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready", 64'(data_in_ready), 64'(1));
        @(posedge clk);
        #1;
        data_in_valid = 1'b0;
    endtask

    task automatic send_tile();
        for (int b = 0; b < ID; b++) send_beat(pack_beat(b));
        model_push();
        check("latency_valid", 64'(data_out_valid), 64'(1));
        check("drain_in_ready", 64'(data_in_ready), 64'(0));
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_d.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_done", 64'(exp_d.size()), 64'(0));
        @(posedge clk);
        #1;
        check("valid_drop", 64'(data_out_valid), 64'(0));
        check("fill_ready", 64'(data_in_ready), 64'(1));
    endtask

    // Output monitor: ordering, content, stability under backpressure.
    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 1'b0;
            out_idx    = 0;
        end else begin
            if (prev_stall) begin
                check("hold_data", 64'(data_out), 64'(prev_d));
                check("hold_shift", 64'(scale_shift), 64'(prev_s));
                check("hold_in_ready", 64'(data_in_ready), 64'(0));
            end
            if (data_out_valid && data_out_ready) begin
                if (exp_d.size() == 0) begin
                    check("unexpected_beat", 64'(1), 64'(0));
                end else begin
                    check("data", 64'(data_out), 64'(exp_d.pop_front()));
                    check("shift", 64'(scale_shift), 64'(exp_s.pop_front()));
                end
                got_q[out_idx] = data_out;
                got_sh         = scale_shift;
                out_idx        = (out_idx + 1) % ID;
                acc_cnt++;
            end
            if (data_out_valid && !data_out_ready) stall_cnt++;
            prev_stall = data_out_valid && !data_out_ready;
            prev_d     = data_out;
            prev_s     = scale_shift;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"}, 64'(data_out), 64'(0));
        check({tag, "_shift"}, 64'(scale_shift), 64'(0));
        check({tag, "_valid"}, 64'(data_out_valid), 64'(0));
        check({tag, "_in_ready"}, 64'(data_in_ready), 64'(0));
    endtask

    initial begin
        int base_acc, base_stall;
        #12;
        check_reset_outputs("rst0");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // 1/2: small row passes through; row with absmax 1000 uses s=3
        set_row(0, 0, 5, -127, 0, 99);   set_row(0, 1, 1000, 12, -13, 0);
        set_row(1, 0, 127, -1, 2, -3);   set_row(1, 1, -500, 7, 8, 9);
        set_row(2, 0, 10, 20, 30, 40);   set_row(2, 1, 0, 0, 0, 1);
        send_tile();
        wait_drain();
        check("t1_s0", 64'(got_sh[0]), 64'(0));
        check("t1_s1", 64'(got_sh[1]), 64'(3));
        check("t1_q5", 64'(gq(0, 0)), 64'(5));
        check("t1_qm127", 64'(gq(0, 1)), 64'(-127));
        check("t1_q99", 64'(gq(0, 3)), 64'(99));
        check("t1_q1000", 64'(gq(0, 4)), 64'(125));
`ifdef LLM_INT8_ABSMAX_ROUND_EN
        check("t1_q12", 64'(gq(0, 5)), 64'(2));
`else
        check("t1_q12", 64'(gq(0, 5)), 64'(1));
`endif
        check("t1_qm13", 64'(gq(0, 6)), 64'(-2));

        // 3: saturation, and the most negative input
        set_row(0, 0, 1020, -1020, 8, 0); set_row(0, 1, -32768, 32767, 100, -1);
        set_row(1, 0, 0, 0, 0, 0);        set_row(1, 1, 0, 0, 0, 0);
        set_row(2, 0, -3, 3, 0, 0);       set_row(2, 1, 512, -512, 0, 0);
        send_tile();
        wait_drain();
        check("t3_s0", 64'(got_sh[0]), 64'(3));
        check("t3_s1", 64'(got_sh[1]), 64'(9));
        check("t3_q1020", 64'(gq(0, 0)), 64'(127));
        check("t3_qm1020", 64'(gq(0, 1)), 64'(-127));
        check("t3_qmin", 64'(gq(0, 4)), 64'(-64));
`ifdef LLM_INT8_ABSMAX_ROUND_EN
        check("t3_qmax", 64'(gq(0, 5)), 64'(64));
`else
        check("t3_qmax", 64'(gq(0, 5)), 64'(63));
`endif

        // 4: all-zero row next to a row with absmax 255
        set_row(0, 0, 0, 0, 0, 0); set_row(0, 1, 200, -255, 3, -3);
        set_row(1, 0, 0, 0, 0, 0); set_row(1, 1, 1, 1, 1, 1);
        set_row(2, 0, 0, 0, 0, 0); set_row(2, 1, 0, 0, 0, 0);
        send_tile();
        wait_drain();
        check("t4_s0", 64'(got_sh[0]), 64'(0));
        check("t4_s1", 64'(got_sh[1]), 64'(1));
        check("t4_zero", 64'(got_q[0][IS-1:0]), 64'(0));
        check("t4_q200", 64'(gq(0, 4)), 64'(100));
        check("t4_qm255", 64'(gq(0, 5)), 64'(-127));

        // 5: five stalled cycles in the middle of DRAIN
        set_row(0, 0, 300, -300, 7, -8); set_row(0, 1, 40, -41, 42, -43);
        set_row(1, 0, 150, 151, -152, 0); set_row(1, 1, 60, 61, 62, 63);
        set_row(2, 0, -1, -2, -3, -4);   set_row(2, 1, -60, -61, -62, -63);
        base_acc   = acc_cnt;
        base_stall = stall_cnt;
        fork
            send_tile();
            begin
                int n = 0;
                while (acc_cnt < base_acc + 1 && n < 100) begin
                    @(posedge clk);
                    n++;
                end
                @(posedge clk);
                #1;
                data_out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                data_out_ready = 1'b1;
            end
        join
        wait_drain();
        check("t5_beats", 64'(acc_cnt - base_acc), 64'(3));
        check("t5_stalls", 64'(stall_cnt - base_stall), 64'(5));

        // 6: reset after two beats, then a fresh small tile
        set_row(0, 0, 5000, -5000, 1, 1); set_row(0, 1, 20000, 0, 0, 0);
        send_beat(pack_beat(0));
        send_beat(pack_beat(0));
        rst = 1'b0;
        #2;
        check_reset_outputs("rst1");
        @(negedge clk);
        check_reset_outputs("rst2");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        set_row(0, 0, 50, -50, 1, 2);   set_row(0, 1, 10, -10, 0, 49);
        set_row(1, 0, -49, 0, 0, 0);    set_row(1, 1, 50, 0, 0, -1);
        set_row(2, 0, 3, 3, 3, 3);      set_row(2, 1, -50, 0, 0, 0);
        send_tile();
        wait_drain();
        check("t6_s0", 64'(got_sh[0]), 64'(0));
        check("t6_s1", 64'(got_sh[1]), 64'(0));
        check("t6_q50", 64'(gq(0, 0)), 64'(50));
        check("t6_qm50", 64'(gq(0, 1)), 64'(-50));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
